mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter for a word-wide byte memory.
// Sub-word stores are sequenced as read-modify-write through the MERGE state.
module mem_arbiter #(
  parameter bit PRIORITY = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [31:0]     i_addr,
  output logic            i_ack,
  output logic [0:3][7:0] i_rdata,
  input  logic            d_req,
  input  logic [31:0]     d_addr,
  input  logic            d_we,
  input  logic [3:0]      d_be,
  input  logic [0:3][7:0] d_wdata,
  output logic            d_ack,
  output logic [0:3][7:0] d_rdata,
  output logic [31:0]     mem_addr,
  output logic            mem_we,
  output logic [0:3][7:0] mem_wdata,
  input  logic [0:3][7:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  state_t          state;
  logic            gnt_d;
  logic            last_d;
  logic            we_q;
  logic [3:0]      be_q;
  logic [0:3][7:0] wdata_q;
  logic [0:3][7:0] merged;
  logic            pick_d;

  // D wins when alone, when ties are fixed-priority, or when I was granted last.
  always_comb begin
    pick_d = d_req && (!i_req || PRIORITY || !last_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_d    <= 1'b0;
      last_d   <= 1'b1;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            gnt_d  <= pick_d;
            last_d <= pick_d;
            if (pick_d) begin
              mem_addr <= d_addr;
              we_q     <= d_we;
              be_q     <= d_be;
              wdata_q  <= d_wdata;
              mem_we   <= d_we && (d_be == 4'hF);
            end else begin
              mem_addr <= i_addr;
              we_q     <= 1'b0;
              be_q     <= '0;
              wdata_q  <= '0;
              mem_we   <= 1'b0;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_q && (be_q != 4'h0) && (be_q != 4'hF)) begin
            mem_we <= 1'b1;
            state  <= MERGE;
          end else begin
            mem_we <= 1'b0;
            i_ack  <= !gnt_d;
            d_ack  <= gnt_d;
            state  <= RESP;
          end
        end
        MERGE: begin
          mem_we <= 1'b0;
          i_ack  <= !gnt_d;
          d_ack  <= gnt_d;
          state  <= RESP;
        end
        RESP: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data arrives one cycle after the address, so merge and response
  // data are taken combinationally from mem_rdata in MERGE/RESP.
  always_comb begin
    merged = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      merged[k] = be_q[k] ? wdata_q[k] : mem_rdata[k];
    end
  end

  always_comb begin
    mem_wdata = '0;
    if (mem_we) begin
      mem_wdata = (state == MERGE) ? merged : wdata_q;
    end
  end

  always_comb begin
    i_rdata = i_ack ? mem_rdata : '0;
    d_rdata = (d_ack && !we_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read word memory model.
// A second instance with PRIORITY=1 shares the inputs for the fixed-priority case.
module tb_mem_arbiter;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_req;
  logic [31:0]     i_addr;
  logic            i_ack;
  logic [0:3][7:0] i_rdata;
  logic            d_req;
  logic [31:0]     d_addr;
  logic            d_we;
  logic [3:0]      d_be;
  logic [0:3][7:0] d_wdata;
  logic            d_ack;
  logic [0:3][7:0] d_rdata;
  logic [31:0]     mem_addr;
  logic            mem_we;
  logic [0:3][7:0] mem_wdata;
  logic [0:3][7:0] mem_rdata;

  logic            p_i_ack;
  logic [0:3][7:0] p_i_rdata;
  logic            p_d_ack;
  logic [0:3][7:0] p_d_rdata;
  logic [31:0]     p_mem_addr;
  logic            p_mem_we;
  logic [0:3][7:0] p_mem_wdata;

  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.PRIORITY(1'b0)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.PRIORITY(1'b1)) dut_p (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(p_i_ack), .i_rdata(p_i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
    .d_ack(p_d_ack), .d_rdata(p_d_rdata),
    .mem_addr(p_mem_addr), .mem_we(p_mem_we), .mem_wdata(p_mem_wdata), .mem_rdata(mem_rdata)
  );

  // Registered-read memory: read returns the old word when written at the same edge.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[11:2]];
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pre_idx = addr[11:2];
    pre_data = data;
    pre_we = 1'b1;
    cyc();
    pre_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Issues one request in the current (IDLE) cycle, which is cycle 0.
  task automatic do_acc(input bit is_d, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int ack_at, output logic [31:0] rd,
                        output logic [15:0] wem, output logic [31:0] wd_seen,
                        output bit other_ack);
    ack_at = -1; rd = '0; wem = '0; wd_seen = '0; other_ack = 1'b0;
    if (is_d) begin
      d_req = 1'b1; d_addr = addr; d_we = we; d_be = be; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int n = 1; n <= 10; n++) begin
      cyc();
      if (mem_we) begin
        wem[n] = 1'b1;
        wd_seen = mem_wdata;
      end
      if (is_d ? i_ack : d_ack) other_ack = 1'b1;
      if (is_d ? d_ack : i_ack) begin
        ack_at = n;
        rd = is_d ? d_rdata : i_rdata;
        break;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_at;
    logic [31:0] rd;
    logic [15:0] wem;
    logic [31:0] wds;
    bit oth;
    int ia;
    int da;
    logic [31:0] rdv;
    logic [15:0] mi, md, pi, pd;

    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_addr = '0; d_we = 1'b0; d_be = '0; d_wdata = '0;
    cyc();
    preload(32'h100, 32'h11223344);
    preload(32'h200, 32'hCAFEF00D);
    preload(32'h400, 32'h11223344);
    do_reset();

    check_eq("rst_i_ack", 32'(i_ack), 32'd0);
    check_eq("rst_d_ack", 32'(d_ack), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_i_rdata", i_rdata, 32'd0);
    check_eq("rst_d_rdata", d_rdata, 32'd0);

    // Tie straight after reset: I first (last grant resets to D), then D.
    ia = -1; da = -1; rdv = '0;
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_addr = 32'h200; d_we = 1'b0; d_be = 4'hF;
    for (int n = 1; n <= 10; n++) begin
      cyc();
      if (i_ack && ia < 0) begin ia = n; i_req = 1'b0; end
      if (d_ack && da < 0) begin da = n; rdv = d_rdata; d_req = 1'b0; end
      if (ia >= 0 && da >= 0) break;
    end
    cyc();
    check_eq("tie_i_ack_cycle", 32'(ia), 32'd2);
    check_eq("tie_d_ack_cycle", 32'(da), 32'd5);
    check_eq("tie_d_rdata", rdv, 32'hCAFEF00D);

    do_acc(1'b0, 1'b0, 4'h0, 32'h102, 32'h0, ack_at, rd, wem, wds, oth);
    check_eq("fetch_ack_cycle", 32'(ack_at), 32'd2);
    check_eq("fetch_rdata", rd, 32'h11223344);
    check_eq("fetch_no_d_ack", 32'(oth), 32'd0);
    check_eq("fetch_no_we", 32'(wem), 32'd0);
    check_eq("idle_i_rdata_zero", i_rdata, 32'd0);

    do_acc(1'b1, 1'b1, 4'b0010, 32'h100, 32'h55AA6677, ack_at, rd, wem, wds, oth);
    check_eq("pst_ack_cycle", 32'(ack_at), 32'd3);
    check_eq("pst_we_cycles", 32'(wem), 32'h0004);
    check_eq("pst_wdata", wds, 32'h11AA3344);
    check_eq("pst_rdata_zero", rd, 32'd0);
    check_eq("pst_no_i_ack", 32'(oth), 32'd0);
    do_acc(1'b1, 1'b0, 4'h0, 32'h100, 32'h0, ack_at, rd, wem, wds, oth);
    check_eq("pst_load_cycle", 32'(ack_at), 32'd2);
    check_eq("pst_load_data", rd, 32'h11AA3344);

    do_acc(1'b1, 1'b1, 4'hF, 32'h300, 32'hDEADBEEF, ack_at, rd, wem, wds, oth);
    check_eq("fst_ack_cycle", 32'(ack_at), 32'd2);
    check_eq("fst_we_cycles", 32'(wem), 32'h0002);
    check_eq("fst_wdata", wds, 32'hDEADBEEF);
    do_acc(1'b1, 1'b0, 4'h0, 32'h300, 32'h0, ack_at, rd, wem, wds, oth);
    check_eq("fst_load_data", rd, 32'hDEADBEEF);

    do_acc(1'b1, 1'b1, 4'h0, 32'h300, 32'h12345678, ack_at, rd, wem, wds, oth);
    check_eq("zst_ack_cycle", 32'(ack_at), 32'd2);
    check_eq("zst_we_cycles", 32'(wem), 32'd0);
    do_acc(1'b1, 1'b0, 4'h0, 32'h300, 32'h0, ack_at, rd, wem, wds, oth);
    check_eq("zst_load_data", rd, 32'hDEADBEEF);

    do_acc(1'b1, 1'b1, 4'b1001, 32'h300, 32'h01020304, ack_at, rd, wem, wds, oth);
    check_eq("edge_pst_ack_cycle", 32'(ack_at), 32'd3);
    check_eq("edge_pst_wdata", wds, 32'h01ADBE04);
    do_acc(1'b1, 1'b0, 4'h0, 32'h300, 32'h0, ack_at, rd, wem, wds, oth);
    check_eq("edge_pst_load_data", rd, 32'h01ADBE04);

    // Continuous requests on both ports for 12 cycles.
    do_reset();
    mi = '0; md = '0; pi = '0; pd = '0;
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_addr = 32'h200; d_we = 1'b0; d_be = 4'h0;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      mi[n] = i_ack; md[n] = d_ack;
      pi[n] = p_i_ack; pd[n] = p_d_ack;
    end
    i_req = 1'b0; d_req = 1'b0;
    cyc(); cyc(); cyc();
    check_eq("rr_i_acks", 32'(mi), 32'h0104);
    check_eq("rr_d_acks", 32'(md), 32'h0820);
    check_eq("prio_i_acks", 32'(pi), 32'h0000);
    check_eq("prio_d_acks", 32'(pd), 32'h0924);

    // Reset asserted during the MERGE cycle of a partial store.
    do_reset();
    d_req = 1'b1; d_addr = 32'h400; d_we = 1'b1; d_be = 4'b0100; d_wdata = 32'h0000BB00;
    cyc();
    cyc();
    check_eq("rm_merge_we", 32'(mem_we), 32'd1);
    check_eq("rm_merge_wdata", mem_wdata, 32'h1122BB44);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_eq("rm_i_ack", 32'(i_ack), 32'd0);
    check_eq("rm_d_ack", 32'(d_ack), 32'd0);
    check_eq("rm_mem_we", 32'(mem_we), 32'd0);
    check_eq("rm_mem_addr", mem_addr, 32'd0);
    check_eq("rm_mem_wdata", mem_wdata, 32'd0);
    check_eq("rm_d_rdata", d_rdata, 32'd0);
    check_eq("rm_mem_word", mem[32'h400 >> 2], 32'h1122BB44);
    do_acc(1'b1, 1'b1, 4'b0100, 32'h400, 32'h0000BB00, ack_at, rd, wem, wds, oth);
    check_eq("rm_reissue_ack_cycle", 32'(ack_at), 32'd3);
    check_eq("rm_reissue_wdata", wds, 32'h1122BB44);
    do_acc(1'b1, 1'b0, 4'h0, 32'h400, 32'h0, ack_at, rd, wem, wds, oth);
    check_eq("rm_load_data", rd, 32'h1122BB44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
